// File: rtl/vlan_tag_inserter.sv
// VLAN tag inserter: adds an 802.1Q tag after the 12 MAC address bytes
// of a byte-stream frame, with per-frame TCI sampling and statistics.
module vlan_tag_inserter #(
    parameter logic [15:0] TPID  = 16'h8100,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    input  logic             tag_en,
    input  logic [11:0]      vlan_id,
    input  logic [2:0]       pcp,
    input  logic             dei,
    output logic [CNT_W-1:0] tagged_cnt,
    output logic [CNT_W-1:0] runt_cnt,
    output logic             runt_err
);

    typedef enum logic [1:0] {IDLE, MAC, TAG, BODY} state_t;

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic [1:0]  t, t_nx;
    logic [15:0] tci_q;
    logic        load, acc;
    logic        out_ld, out_last;
    logic [7:0]  out_data;
    logic        sample, runt_now, tag_done;
    logic [7:0]  tag_byte;

    assign load    = !m_valid || m_ready;
    assign s_ready = load && (state != TAG);
    assign acc     = s_valid && s_ready;

    always_comb begin
        tag_byte = TPID[15:8];
        unique case (t)
            2'd0: tag_byte = TPID[15:8];
            2'd1: tag_byte = TPID[7:0];
            2'd2: tag_byte = tci_q[15:8];
            2'd3: tag_byte = tci_q[7:0];
        endcase
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        t_nx     = t;
        out_ld   = 1'b0;
        out_data = s_data;
        out_last = s_last;
        sample   = 1'b0;
        runt_now = 1'b0;
        tag_done = 1'b0;
        unique case (state)
            IDLE: if (acc) begin
                out_ld = 1'b1;
                sample = 1'b1;
                idx_nx = 4'd1;
                if (s_last) begin
                    runt_now = tag_en;
                    state_nx = IDLE;
                end else if (tag_en) begin
                    state_nx = MAC;
                end else begin
                    state_nx = BODY;
                end
            end
            // Only tagged frames pass through MAC, so an early last is a runt.
            MAC: if (acc) begin
                out_ld = 1'b1;
                idx_nx = idx + 4'd1;
                if (s_last) begin
                    runt_now = 1'b1;
                    state_nx = IDLE;
                end else if (idx == 4'd11) begin
                    state_nx = TAG;
                    t_nx     = 2'd0;
                end
            end
            TAG: if (load) begin
                out_ld   = 1'b1;
                out_data = tag_byte;
                out_last = 1'b0;
                t_nx     = t + 2'd1;
                if (t == 2'd3) begin
                    tag_done = 1'b1;
                    state_nx = BODY;
                end
            end
            BODY: if (acc) begin
                out_ld = 1'b1;
                if (s_last) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 4'd0;
            t     <= 2'd0;
            tci_q <= 16'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            t     <= t_nx;
            if (sample) tci_q <= {pcp, dei, vlan_id};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= 8'd0;
            m_last  <= 1'b0;
        end else if (out_ld) begin
            m_valid <= 1'b1;
            m_data  <= out_data;
            m_last  <= out_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tagged_cnt <= '0;
            runt_cnt   <= '0;
            runt_err   <= 1'b0;
        end else begin
            runt_err <= runt_now;
            if (tag_done && tagged_cnt != '1)
                tagged_cnt <= tagged_cnt + CNT_W'(1);
            if (runt_now && runt_cnt != '1)
                runt_cnt <= runt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vlan_tag_inserter.sv
// Bench for vlan_tag_inserter: vector table, corner sequences and
// randomized frames against a frame-level reference model.
module tb_vlan_tag_inserter;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid, s_ready, s_last;
    logic [7:0]    s_data;
    logic          m_valid, m_ready, m_last;
    logic [7:0]    m_data;
    logic          tag_en, dei;
    logic [11:0]   vlan_id;
    logic [2:0]    pcp;
    logic [CW-1:0] tagged_cnt, runt_cnt;
    logic          runt_err;

    vlan_tag_inserter #(.TPID(16'h8100), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last),
        .tag_en(tag_en), .vlan_id(vlan_id),
        .pcp(pcp), .dei(dei),
        .tagged_cnt(tagged_cnt), .runt_cnt(runt_cnt),
        .runt_err(runt_err)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        int          len;
        bit          tag;
        logic [11:0] vid;
        logic [2:0]  pcp;
        bit          dei;
        int          exp_len;
        logic [31:0] exp_tag;
        int          exp_runt;
    } vec_t;

    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  exp_tagged = 0, exp_runt = 0;
    int  runt_pulses = 0, exp_pulses = 0;
    bit  rand_ready = 0, rand_gap = 0, scramble = 0, abort = 0;

    task automatic chk(input string nm, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: collects transfers, checks hold stability, counts runt pulses.
    initial begin
        bit         hold;
        logic [7:0] hd;
        logic       hl;
        hold = 0;
        hd = 0;
        hl = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
            end else begin
                if (hold) begin
                    compared++;
                    if (!m_valid || m_data != hd || m_last != hl) begin
                        mismatched++;
                        $display("FAIL hold: got v=%0b d=%02h l=%0b expected v=1 d=%02h l=%0b",
                                 m_valid, m_data, m_last, hd, hl);
                    end
                end
                if (m_valid && m_ready) rx_q.push_back({m_last, m_data});
                if (runt_err) runt_pulses++;
                hold = m_valid && !m_ready;
                hd = m_data;
                hl = m_last;
            end
        end
    end

    // Frame-level model: tag goes after byte 11 only if the frame is longer than 12.
    task automatic model(input bq_t fr, input bit tag, input logic [15:0] tci);
        bit ins;
        ins = tag && fr.size() > 12;
        for (int i = 0; i < fr.size(); i++) begin
            if (ins && i == 12) begin
                exp_q.push_back({1'b0, 8'h81});
                exp_q.push_back({1'b0, 8'h00});
                exp_q.push_back({1'b0, tci[15:8]});
                exp_q.push_back({1'b0, tci[7:0]});
            end
            exp_q.push_back({i == fr.size() - 1, fr[i]});
        end
        if (ins) exp_tagged++;
        else if (tag) begin
            exp_runt++;
            exp_pulses++;
        end
    endtask

    task automatic send(input bq_t fr, input bit tag, input logic [11:0] vid,
                        input logic [2:0] p, input bit d);
        bit got, ok;
        for (int i = 0; i < fr.size(); i++) begin
            if (abort) break;
            if (rand_gap) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (i == 0) begin
                tag_en = tag;
                vlan_id = vid;
                pcp = p;
                dei = d;
            end
            s_valid = 1'b1;
            s_data = fr[i];
            s_last = (i == fr.size() - 1);
            ok = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                got = s_ready && rst_n;
                @(posedge clk);
                #1;
                if (got) begin
                    ok = 1;
                    break;
                end
                if (abort) break;
            end
            if (!ok && !abort) chk("accept_timeout", 0, 1);
            if (i == 0 && scramble) begin
                tag_en = 1'($urandom_range(0, 1));
                vlan_id = 12'($urandom);
                pcp = 3'($urandom);
                dei = 1'($urandom_range(0, 1));
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic rand_frame(input int len, output bq_t fr);
        fr = {};
        for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
    endtask

    task automatic drain_cmp(input string nm);
        int n, m;
        n = 0;
        while (rx_q.size() < exp_q.size() && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_len"}, rx_q.size(), exp_q.size());
        m = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_byte%0d", nm, i), rx_q[i], exp_q[i]);
        chk({nm, "_tagged_cnt"}, tagged_cnt, sat(exp_tagged));
        chk({nm, "_runt_cnt"}, runt_cnt, sat(exp_runt));
        chk({nm, "_runt_pulses"}, runt_pulses, exp_pulses);
    endtask

    vec_t vecs[8];

    initial begin
        bq_t fr;
        int  p0;
        vecs[0] = '{64, 1, 12'h064, 3'd5, 1'b0, 68, 32'h8100A064, 0};
        vecs[1] = '{64, 0, 12'h064, 3'd5, 1'b0, 64, 32'h0, 0};
        vecs[2] = '{10, 1, 12'h123, 3'd1, 1'b0, 10, 32'h0, 1};
        vecs[3] = '{12, 1, 12'h123, 3'd1, 1'b0, 12, 32'h0, 1};
        vecs[4] = '{13, 1, 12'hFFF, 3'd7, 1'b1, 17, 32'h8100FFFF, 0};
        vecs[5] = '{1, 1, 12'h001, 3'd0, 1'b0, 1, 32'h0, 1};
        vecs[6] = '{1, 0, 12'h001, 3'd0, 1'b0, 1, 32'h0, 0};
        vecs[7] = '{14, 1, 12'hABC, 3'd2, 1'b1, 18, 32'h81005ABC, 0};

        rst_n = 1'b0;
        s_valid = 0; s_data = 0; s_last = 0;
        tag_en = 0; vlan_id = 0; pcp = 0; dei = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_runt_err", runt_err, 0);
        chk("rst_tagged_cnt", tagged_cnt, 0);
        chk("rst_runt_cnt", runt_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            rand_frame(vecs[v].len, fr);
            p0 = runt_pulses;
            model(fr, vecs[v].tag, {vecs[v].pcp, vecs[v].dei, vecs[v].vid});
            send(fr, vecs[v].tag, vecs[v].vid, vecs[v].pcp, vecs[v].dei);
            drain_cmp($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_outlen", v), rx_q.size(), vecs[v].exp_len);
            chk($sformatf("vec%0d_pulse", v), runt_pulses - p0, vecs[v].exp_runt);
            if (vecs[v].exp_len > vecs[v].len && rx_q.size() >= 16)
                chk($sformatf("vec%0d_tag", v),
                    {rx_q[12][7:0], rx_q[13][7:0], rx_q[14][7:0], rx_q[15][7:0]},
                    vecs[v].exp_tag);
            rx_q = {};
            exp_q = {};
        end

        // TCI fields and tag_en change right after byte 0 is accepted.
        scramble = 1;
        rand_frame(20, fr);
        model(fr, 1'b1, {3'd6, 1'b1, 12'h5A5});
        send(fr, 1'b1, 12'h5A5, 3'd6, 1'b1);
        drain_cmp("midframe");
        rx_q = {};
        exp_q = {};

        // Back-to-back random frames under output backpressure and input gaps.
        rand_ready = 1;
        rand_gap = 1;
        for (int f = 0; f < 100; f++) begin
            bit          tg;
            logic [11:0] vid;
            logic [2:0]  pp;
            bit          dd;
            tg = 1'($urandom_range(0, 1));
            vid = 12'($urandom);
            pp = 3'($urandom);
            dd = 1'($urandom_range(0, 1));
            rand_frame($urandom_range(1, 40), fr);
            model(fr, tg, {pp, dd, vid});
            send(fr, tg, vid, pp, dd);
        end
        drain_cmp("random");
        rx_q = {};
        exp_q = {};
        rand_ready = 0;
        rand_gap = 0;
        scramble = 0;

        // Reset while output byte 14 of a tagged frame is being presented.
        rand_frame(64, fr);
        fork
            send(fr, 1'b1, 12'h064, 3'd5, 1'b0);
            begin
                for (int c = 0; c < 2000; c++) begin
                    @(negedge clk);
                    if (rx_q.size() >= 14) break;
                end
                chk("reset_reach_byte14", rx_q.size(), 14);
                #1;
                rst_n = 1'b0;
                abort = 1;
                #1;
                chk("midrst_m_valid", m_valid, 0);
                chk("midrst_tagged_cnt", tagged_cnt, 0);
                chk("midrst_runt_cnt", runt_cnt, 0);
            end
        join
        @(posedge clk);
        #1;
        rx_q = {};
        exp_q = {};
        exp_tagged = 0;
        exp_runt = 0;
        runt_pulses = 0;
        exp_pulses = 0;
        rst_n = 1'b1;
        abort = 0;
        @(negedge clk);
        chk("postrst_s_ready", s_ready, 1);
        @(posedge clk);
        #1;
        rand_frame(60, fr);
        model(fr, 1'b1, {3'd3, 1'b0, 12'h2B7});
        send(fr, 1'b1, 12'h2B7, 3'd3, 1'b0);
        drain_cmp("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
